// File: rtl/vram_dma_pkg.sv
// -----------------------------------------------------------------------------
// vram_dma_pkg
// Shared definitions for the RAM->VRAM copy engine:
//   ADDR_W        word-address width of the data-memory index
//   LEN_W         width of the transfer-length field
//   VRAM_WORDS    number of texture words held in VRAM
//   VRAM_SEL_BIT  data-memory address bit that selects VRAM instead of RAM
//   state_e       copy-engine FSM states
// -----------------------------------------------------------------------------
package vram_dma_pkg;

  localparam int ADDR_W       = 14;
  localparam int LEN_W        = 12;
  localparam int VRAM_WORDS   = 2240;
  localparam int VRAM_SEL_BIT = 14;

  // IDLE is encoded as zero so a cleared state register reads as idle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/dmem_port_mux.sv
// -----------------------------------------------------------------------------
// dmem_port_mux
// Combinational owner-select for the single shared data-memory port.
// The CPU always wins. The copy engine drives the port only while it is
// actively reading or writing; otherwise the port carries the CPU address and
// write data with the write enable forced low.
//
// Ports:
//   cpu_req_i             CPU uses data memory this cycle
//   cpu_we_i/a_i/wd_i     CPU memory command
//   dma_act_i             copy engine is in a read or write state
//   dma_we_i/a_i/wd_i     copy engine memory command
//   mem_we_o/a_o/wd_o     command presented to the data memory
// -----------------------------------------------------------------------------
module dmem_port_mux
  import vram_dma_pkg::*;
(
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_a_i,
  input  logic [31:0] cpu_wd_i,
  input  logic        dma_act_i,
  input  logic        dma_we_i,
  input  logic [31:0] dma_a_i,
  input  logic [31:0] dma_wd_i,
  output logic        mem_we_o,
  output logic [31:0] mem_a_o,
  output logic [31:0] mem_wd_o
);

  always_comb begin
    mem_we_o = 1'b0;
    mem_a_o  = cpu_a_i;
    mem_wd_o = cpu_wd_i;
    if (cpu_req_i) begin
      mem_we_o = cpu_we_i;
      mem_a_o  = cpu_a_i;
      mem_wd_o = cpu_wd_i;
    end else if (dma_act_i) begin
      mem_we_o = dma_we_i;
      mem_a_o  = dma_a_i;
      mem_wd_o = dma_wd_i;
    end
  end

endmodule

// File: rtl/vram_dma.sv
// -----------------------------------------------------------------------------
// vram_dma
// Copies a block of words from data RAM into texture VRAM over the data-memory
// port it shares with the CPU. Each word takes a read cycle followed by a
// write cycle; any cycle in which the CPU requests memory stalls the whole
// engine (state, pointers, length and data register all hold).
//
// Handshake: start is a single-cycle request sampled in IDLE on a cycle with
// no CPU request. It is accepted when dst+len fits inside VRAM (busy rises the
// next cycle, or the engine goes straight to FIN for len=0) and rejected
// otherwise (err pulses the next cycle). Completion is a one-cycle done pulse
// in the cycle after FIN. start is ignored outside IDLE.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start, src, dst, len  copy request: RAM index, VRAM index, word count
//   cpu_req/we/a/wd       CPU memory command (priority owner of the port)
//   mem_we/a/wd           command to the shared data-memory port
//   mem_rd                combinational read data from data memory
//   cpu_rd                mem_rd passed through to the CPU
//   busy, done, err       status: copying, completion pulse, reject pulse
//   dbg_state             current FSM state encoding
// -----------------------------------------------------------------------------
module vram_dma #(
  parameter int ADDR_W     = vram_dma_pkg::ADDR_W,
  parameter int LEN_W      = vram_dma_pkg::LEN_W,
  parameter int VRAM_WORDS = vram_dma_pkg::VRAM_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_a,
  input  logic [31:0]       cpu_wd,
  output logic              mem_we,
  output logic [31:0]       mem_a,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd,
  output logic [31:0]       cpu_rd,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        dbg_state
);

  import vram_dma_pkg::*;

  state_e              state_q;
  logic [ADDR_W-1:0]   src_q;
  logic [ADDR_W-1:0]   dst_q;
  logic [LEN_W-1:0]    rem_q;
  logic [31:0]         data_q;
  logic                done_q;
  logic                err_q;

  // One extra bit so dst+len can never wrap and sneak past the bound check.
  logic [ADDR_W:0]     end_idx;
  logic                fits;

  logic                dma_act;
  logic                dma_we;
  logic [31:0]         dma_a;
  logic [31:0]         dma_wd;

  assign end_idx = {1'b0, dst} + (ADDR_W+1)'(len);
  assign fits    = (end_idx <= (ADDR_W+1)'(VRAM_WORDS));

  // ---------------------------------------------------------------------------
  // Copy-engine memory command, derived from registered state only.
  // Reads address RAM (select bit clear); writes address VRAM (select bit set).
  // ---------------------------------------------------------------------------
  assign dma_act = (state_q == ST_RD) || (state_q == ST_WR);

  always_comb begin
    dma_we = 1'b0;
    dma_a  = '0;
    dma_wd = data_q;
    if (state_q == ST_WR) begin
      dma_we                  = 1'b1;
      dma_a[ADDR_W-1:0]       = dst_q;
      dma_a[VRAM_SEL_BIT]     = 1'b1;
    end else begin
      dma_a[ADDR_W-1:0]       = src_q;
    end
  end

  dmem_port_mux u_mux (
    .cpu_req_i (cpu_req),
    .cpu_we_i  (cpu_we),
    .cpu_a_i   (cpu_a),
    .cpu_wd_i  (cpu_wd),
    .dma_act_i (dma_act),
    .dma_we_i  (dma_we),
    .dma_a_i   (dma_a),
    .dma_wd_i  (dma_wd),
    .mem_we_o  (mem_we),
    .mem_a_o   (mem_a),
    .mem_wd_o  (mem_wd)
  );

  // ---------------------------------------------------------------------------
  // FSM, pointers, remaining count and data register.
  // A CPU request freezes everything; done/err are pulses and drop back to 0
  // on every cycle they are not explicitly set.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (!cpu_req) begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              if (fits) begin
                src_q   <= src;
                dst_q   <= dst;
                rem_q   <= len;
                state_q <= (len == '0) ? ST_FIN : ST_RD;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          ST_RD: begin
            data_q  <= mem_rd;
            state_q <= ST_WR;
          end
          ST_WR: begin
            // src wraps naturally at 2^ADDR_W; dst is bounded by acceptance.
            src_q   <= src_q + ADDR_W'(1);
            dst_q   <= dst_q + ADDR_W'(1);
            rem_q   <= rem_q - LEN_W'(1);
            state_q <= (rem_q > LEN_W'(1)) ? ST_RD : ST_FIN;
          end
          ST_FIN: begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy      = dma_act;
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_rd    = mem_rd;
  assign dbg_state = state_q;

endmodule
